// File: rtl/sbox_share_encoder_2om.sv
// Second-order masking front end: splits each accepted byte into three Boolean
// shares using a 32-step leap-ahead Galois LFSR, plus a 6-bit fresh-randomness word.
module sbox_share_encoder_2om #(
    parameter int unsigned WIDTH         = 8,
    parameter logic [31:0] LFSR_POLY     = 32'h8020_0003,
    parameter logic [31:0] SEED_DEFAULT  = 32'hACE1_2468,
    parameter int unsigned RESEED_PERIOD = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic [WIDTH-1:0] x3,
    output logic [5:0]       r,
    output logic             reseed_req
);

    localparam int unsigned CW = $clog2(RESEED_PERIOD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(RESEED_PERIOD);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESEED_PERIOD - 1);

    logic [31:0]      lfsr;
    logic [31:0]      lfsr_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] m1;
    logic [WIDTH-1:0] m2;
    logic [5:0]       rr;
    logic             acc;

    // Advance 32 single Galois steps so consecutive draws share no state bits.
    function automatic logic [31:0] lfsr_leap(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int unsigned i = 0; i < 32; i++) begin
            v = v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
        end
        return v;
    endfunction

    always_comb begin
        lfsr_next = lfsr_leap(lfsr);
        m1        = lfsr[WIDTH-1:0];
        m2        = lfsr[2*WIDTH-1:WIDTH];
        rr        = lfsr[21:16];
    end

    assign in_ready = !seed_load && (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr       <= SEED_DEFAULT;
            out_valid  <= 1'b0;
            x1         <= '0;
            x2         <= '0;
            x3         <= '0;
            r          <= '0;
            cnt        <= '0;
            reseed_req <= 1'b0;
        end else if (seed_load) begin
            lfsr       <= (seed == '0) ? SEED_DEFAULT : seed;
            out_valid  <= 1'b0;
            cnt        <= '0;
            reseed_req <= 1'b0;
        end else if (acc) begin
            // Mask applied before the second share so no unmasked value is formed.
            x1        <= (in_data ^ m1) ^ m2;
            x2        <= m1;
            x3        <= m2;
            r         <= rr;
            out_valid <= 1'b1;
            lfsr      <= lfsr_next;
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CNT_LAST) begin
                reseed_req <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
